// File: rtl/noc_link_pipe_stage_pkg.sv
// Shared definitions for the NoC link pipeline stage: flit width default,
// packet-tracker state encoding and performance-counter width.
package noc_link_pipe_stage_pkg;

   localparam int FLIT_WIDTH_DEF = 80;
   localparam int CNT_WIDTH      = 32;

   typedef enum logic {
      PKT_IDLE = 1'b0,
      PKT_BODY = 1'b1
   } pkt_state_e;

   // Storage word: tail marker sits above the flit payload.
   typedef struct packed {
      logic                      tail;
      logic [FLIT_WIDTH_DEF-1:0] flit;
   } flit_entry_t;

endpackage

// File: rtl/noc_link_fifo.sv
// Circular flit FIFO for the link pipe stage; pointers wrap at DEPTH-1 so
// non-power-of-2 depths work. Exposes next-cycle fullness for a registered stall.
module noc_link_fifo #(
   parameter int W         = 81,
   parameter int DEPTH     = 4,
   parameter int LOG_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         empty_o,
   output logic         full_next_o
);

   localparam logic [LOG_DEPTH-1:0] PTR_LAST = LOG_DEPTH'(DEPTH - 1);
   localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH + 1)'(DEPTH);

   logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG_DEPTH:0]   count_q, count_d;
   logic                 do_push, do_pop;
   logic [DEPTH-1:0]     we;
   logic [W-1:0]         mem_q [DEPTH];

   assign do_push = push_i & (count_q != CNT_FULL);
   assign do_pop  = pop_i & (count_q != '0);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = do_push & (wr_ptr_q == LOG_DEPTH'(gi));
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + LOG_DEPTH'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + LOG_DEPTH'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (LOG_DEPTH + 1)'(1);
         2'b01:   count_d = count_q - (LOG_DEPTH + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entries are cleared on reset so the head output reads zero straight away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we[i]) mem_q[i] <= push_data_i;
         end
      end
   end

   assign head_o      = mem_q[rd_ptr_q];
   assign empty_o     = (count_q == '0);
   assign full_next_o = (count_d == CNT_FULL);

endmodule

// File: rtl/noc_link_pipe_stage.sv
// Elastic NoC link stage: flit FIFO, registered stall, packet tracker, sticky
// overflow flag. Define NOC_LINK_PERF_CNT_EN to add flit/packet pop counters.
module noc_link_pipe_stage
   import noc_link_pipe_stage_pkg::*;
#(
   parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
   parameter int DEPTH      = 4,
   parameter int LOG_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLIT_WIDTH-1:0] FLIT_in,
   input  logic                  VALID_in,
   input  logic                  FWDAUX1_in,
   output logic                  BWDAUX1_out,
   output logic                  BWDAUX2_out,
   output logic                  BWDAUX3_out,
   output logic [FLIT_WIDTH-1:0] FLIT_out,
   output logic                  VALID_out,
   output logic                  FWDAUX1_out,
   input  logic                  BWDAUX1_in,
   input  logic                  BWDAUX2_in,
   input  logic                  BWDAUX3_in,
   output logic                  pkt_active,
   output logic                  ovf_err
`ifdef NOC_LINK_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  flit_cnt,
   output logic [CNT_WIDTH-1:0]  pkt_cnt
`endif
);

   logic                  stall_q, stall_d;
   logic                  bwd2_q, bwd3_q;
   logic                  ovf_q;
   pkt_state_e            state_q;
   logic                  accept, pop, fifo_empty;
   logic [FLIT_WIDTH:0]   head;

   // Stall is registered, so accept only needs the stall the sender also sees.
   assign accept = VALID_in & ~stall_q;
   assign pop    = ~fifo_empty & ~BWDAUX1_in;

   noc_link_fifo #(
      .W         (FLIT_WIDTH + 1),
      .DEPTH     (DEPTH),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (accept),
      .push_data_i ({FWDAUX1_in, FLIT_in}),
      .pop_i       (pop),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .full_next_o (stall_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 1'b0;
         bwd2_q  <= 1'b0;
         bwd3_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         bwd2_q  <= BWDAUX2_in;
         bwd3_q  <= BWDAUX3_in;
         ovf_q   <= ovf_q | (VALID_in & stall_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PKT_IDLE;
      end else begin
         case (state_q)
            PKT_IDLE: if (accept && !FWDAUX1_in) state_q <= PKT_BODY;
            PKT_BODY: if (accept && FWDAUX1_in)  state_q <= PKT_IDLE;
            default:  state_q <= PKT_IDLE;
         endcase
      end
   end

`ifdef NOC_LINK_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] flit_cnt_q, pkt_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flit_cnt_q <= '0;
         pkt_cnt_q  <= '0;
      end else begin
         if (pop) flit_cnt_q <= flit_cnt_q + CNT_WIDTH'(1);
         if (pop && head[FLIT_WIDTH]) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign flit_cnt = flit_cnt_q;
   assign pkt_cnt  = pkt_cnt_q;
`endif

   assign BWDAUX1_out = stall_q;
   assign BWDAUX2_out = bwd2_q;
   assign BWDAUX3_out = bwd3_q;
   assign VALID_out   = pop;
   assign FLIT_out    = head[FLIT_WIDTH-1:0];
   assign FWDAUX1_out = head[FLIT_WIDTH];
   assign pkt_active  = (state_q == PKT_BODY);
   assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_noc_link_pipe_stage.sv
// Scoreboard bench for noc_link_pipe_stage: DEPTH=4 instance for directed
// streaming/fill/reset tests, DEPTH=3 instance for pointer wrap.
module tb_noc_link_pipe_stage;

   localparam int FW = 80;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [FW-1:0] flit_in0, flit_out0, flit_in1, flit_out1;
   logic valid_in0, tail_in0, bwd1_in0, bwd2_in0, bwd3_in0;
   logic bwd1_out0, bwd2_out0, bwd3_out0, valid_out0, tail_out0, pkt0, ovf0;
   logic valid_in1, tail_in1, bwd1_in1, bwd2_in1, bwd3_in1;
   logic bwd1_out1, bwd2_out1, bwd3_out1, valid_out1, tail_out1, pkt1, ovf1;
`ifdef NOC_LINK_PERF_CNT_EN
   logic [31:0] flit_cnt0, pkt_cnt0, flit_cnt1, pkt_cnt1;
`endif

   logic [FW:0] q0[$];
   logic [FW:0] q1[$];
   logic [FW:0] exp0, exp1;
   int n_vec = 0;
   int n_err = 0;

   noc_link_pipe_stage #(.FLIT_WIDTH(FW), .DEPTH(4), .LOG_DEPTH(2)) u0 (
      .clk(clk), .rst(rst), .FLIT_in(flit_in0), .VALID_in(valid_in0), .FWDAUX1_in(tail_in0),
      .BWDAUX1_out(bwd1_out0), .BWDAUX2_out(bwd2_out0), .BWDAUX3_out(bwd3_out0),
      .FLIT_out(flit_out0), .VALID_out(valid_out0), .FWDAUX1_out(tail_out0),
      .BWDAUX1_in(bwd1_in0), .BWDAUX2_in(bwd2_in0), .BWDAUX3_in(bwd3_in0),
      .pkt_active(pkt0), .ovf_err(ovf0)
`ifdef NOC_LINK_PERF_CNT_EN
      , .flit_cnt(flit_cnt0), .pkt_cnt(pkt_cnt0)
`endif
   );

   noc_link_pipe_stage #(.FLIT_WIDTH(FW), .DEPTH(3), .LOG_DEPTH(2)) u1 (
      .clk(clk), .rst(rst), .FLIT_in(flit_in1), .VALID_in(valid_in1), .FWDAUX1_in(tail_in1),
      .BWDAUX1_out(bwd1_out1), .BWDAUX2_out(bwd2_out1), .BWDAUX3_out(bwd3_out1),
      .FLIT_out(flit_out1), .VALID_out(valid_out1), .FWDAUX1_out(tail_out1),
      .BWDAUX1_in(bwd1_in1), .BWDAUX2_in(bwd2_in1), .BWDAUX3_in(bwd3_in1),
      .pkt_active(pkt1), .ovf_err(ovf1)
`ifdef NOC_LINK_PERF_CNT_EN
      , .flit_cnt(flit_cnt1), .pkt_cnt(pkt_cnt1)
`endif
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] mkflit(input int tag);
      return {16'hC0DE, 32'(tag) * 32'h01010101, 32'hF00D0000 + 32'(tag)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input int tag, input logic tail, input bit expect_acc);
      valid_in0 = 1'b1;
      flit_in0  = mkflit(tag);
      tail_in0  = tail;
      if (expect_acc) q0.push_back({tail, mkflit(tag)});
   endtask

   task automatic drain(input bit which);
      for (int i = 0; i < 40; i++) begin
         if ((which ? q1.size() : q0.size()) == 0) break;
         tick();
      end
      check(which ? "drain1_empty" : "drain0_empty", which ? q1.size() : q0.size(), 0);
   endtask

   // Monitors: every presented head flit must match the oldest expected flit.
   always @(negedge clk) begin
      if (!rst && valid_out0) begin
         if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL u0_unexpected_flit: got %h expected none", {tail_out0, flit_out0});
         end else begin
            exp0 = q0.pop_front();
            check("u0_flit", {15'b0, tail_out0, flit_out0}, {15'b0, exp0});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && valid_out1) begin
         if (q1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL u1_unexpected_flit: got %h expected none", {tail_out1, flit_out1});
         end else begin
            exp1 = q1.pop_front();
            check("u1_flit", {15'b0, tail_out1, flit_out1}, {15'b0, exp1});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] pat [4];
      logic [1:0] prev;
      int sent;
      pat = '{2'b01, 2'b10, 2'b11, 2'b00};
      {valid_in0, tail_in0, bwd1_in0, bwd2_in0, bwd3_in0} = '0;
      {valid_in1, tail_in1, bwd1_in1, bwd2_in1, bwd3_in1} = '0;
      flit_in0 = '0;
      flit_in1 = '0;

      // Reset values
      #1 rst = 1'b1;
      #2;
      check("rst_valid_out", valid_out0, 0);
      check("rst_flit_out", flit_out0, 0);
      check("rst_stall", bwd1_out0, 0);
      check("rst_pkt_active", pkt0, 0);
      check("rst_ovf", ovf0, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Streaming 3-flit packet, latency 1
      send0(1, 1'b0, 1); tick();
      check("stream1_valid", valid_out0, 1);
      check("stream1_flit", flit_out0, mkflit(1));
      check("stream1_pkt", pkt0, 1);
      send0(2, 1'b0, 1); tick();
      check("stream2_flit", flit_out0, mkflit(2));
      check("stream2_tail", tail_out0, 0);
      check("stream2_pkt", pkt0, 1);
      send0(3, 1'b1, 1); tick();
      check("stream3_flit", flit_out0, mkflit(3));
      check("stream3_tail", tail_out0, 1);
      check("stream3_pkt", pkt0, 0);
      valid_in0 = 1'b0; tick();
      check("stream_done_valid", valid_out0, 0);

      // Backward sidebands are one-cycle registered copies
      prev = 2'b00;
      for (int i = 0; i < 4; i++) begin
         {bwd3_in0, bwd2_in0} = pat[i];
         #1 check("bwd23_before_edge", {bwd3_out0, bwd2_out0}, prev);
         tick();
         check("bwd23_after_edge", {bwd3_out0, bwd2_out0}, pat[i]);
         prev = pat[i];
      end

      // Fill with downstream stalled
      bwd1_in0 = 1'b1;
      send0(11, 1'b0, 1); tick();
      send0(12, 1'b0, 1); tick();
      send0(13, 1'b0, 1); tick();
      check("fill_stall_after3", bwd1_out0, 0);
      send0(14, 1'b1, 1); tick();
      check("fill_stall_after4", bwd1_out0, 1);
      check("fill_valid_held", valid_out0, 0);
      send0(15, 1'b0, 0); tick();
      valid_in0 = 1'b0;
      check("ovf_set", ovf0, 1);
      check("ovf_stall_held", bwd1_out0, 1);
      check("ovf_drop_fsm", pkt0, 0);

      // Full, downstream releases: pop at t, push+pop at t+1
      bwd1_in0 = 1'b0; tick();
      check("simul_stall_t1", bwd1_out0, 0);
      send0(16, 1'b1, 1); tick();
      valid_in0 = 1'b0;
      check("simul_stall_t2", bwd1_out0, 0);
      drain(0);
      check("ovf_sticky", ovf0, 1);
      check("single_flit_idle", pkt0, 0);

      // Reset mid-packet with 2 flits buffered
      bwd1_in0 = 1'b1;
      bwd2_in0 = 1'b1;
      send0(21, 1'b0, 1); tick();
      send0(22, 1'b0, 1); tick();
      valid_in0 = 1'b0;
      check("midpkt_active", pkt0, 1);
      #2;
      rst = 1'b1;
      bwd1_in0 = 1'b0;
      q0.delete();
      #1;
      check("arst_valid_out", valid_out0, 0);
      check("arst_flit_out", flit_out0, 0);
      check("arst_tail_out", tail_out0, 0);
      check("arst_pkt_active", pkt0, 0);
      check("arst_ovf", ovf0, 0);
      check("arst_stall", bwd1_out0, 0);
      check("arst_bwd2", bwd2_out0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bwd2_in0 = 1'b0;
      send0(23, 1'b0, 1); tick();
      check("post_rst_pkt_body", pkt0, 1);
      check("post_rst_flit", flit_out0, mkflit(23));
      send0(24, 1'b1, 1); tick();
      valid_in0 = 1'b0;
      check("post_rst_pkt_idle", pkt0, 0);
      drain(0);

`ifdef NOC_LINK_PERF_CNT_EN
      #2 rst = 1'b1;
      #1 check("perf_rst_flit_cnt", flit_cnt0, 0);
      @(posedge clk); #1 rst = 1'b0;
      for (int p = 0; p < 5; p++) begin
         send0(30 + 2 * p, 1'b0, 1); tick();
         send0(31 + 2 * p, 1'b1, 1); tick();
      end
      valid_in0 = 1'b0;
      drain(0);
      check("perf_flit_cnt", flit_cnt0, 10);
      check("perf_pkt_cnt", pkt_cnt0, 5);
      check("perf_u1_idle_cnt", flit_cnt1 + pkt_cnt1, 0);
`endif

      // DEPTH=3 wrap: sender honours the registered stall, downstream random
      sent = 0;
      for (int c = 0; c < 300 && sent < 10; c++) begin
         bwd1_in1 = 1'($urandom_range(0, 1));
         if (!bwd1_out1) begin
            valid_in1 = 1'b1;
            flit_in1  = mkflit(100 + sent);
            tail_in1  = sent[0];
            q1.push_back({tail_in1, flit_in1});
            sent++;
         end else begin
            valid_in1 = 1'b0;
         end
         tick();
      end
      valid_in1 = 1'b0;
      bwd1_in1  = 1'b0;
      check("wrap_sent", sent, 10);
      drain(1);
      check("wrap_no_ovf", ovf1, 0);
      check("wrap_pkt_idle", pkt1, 0);
      check("wrap_bwd23", {bwd3_out1, bwd2_out1}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
